// File: rtl/hazard_ctrl_pipe_pkg.sv
// Shared definitions for the pipelined MIPS control path: forward encodings,
// control-word field widths, stage control-word layouts and opcodes.
package hazard_ctrl_pipe_pkg;

  localparam int REG_W    = 5;
  localparam int ALUCTL_W = 3;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // Opcodes decoded by Controller; kept here so both blocks agree.
  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_BEQ   = 6'h04,
    OP_ADDI  = 6'h08,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2b
  } opcode_e;

  typedef struct packed {
    logic                reg_write;
    logic                mem_to_reg;
    logic                mem_write;
    logic                branch;
    logic                alu_src;
    logic                reg_dst;
    logic [ALUCTL_W-1:0] alu_ctl;
    logic [REG_W-1:0]    rs;
    logic [REG_W-1:0]    rt;
    logic [REG_W-1:0]    rd;
  } de_word_t;

  typedef struct packed {
    logic             reg_write;
    logic             mem_to_reg;
    logic             mem_write;
    logic             branch;
    logic             zero;
    logic [REG_W-1:0] write_reg;
  } em_word_t;

  typedef struct packed {
    logic             reg_write;
    logic             mem_to_reg;
    logic [REG_W-1:0] write_reg;
  } mw_word_t;

  // M wins over W; $0 is hardwired so it is never a forwarding source.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_W-1:0] src,
    input logic             rw_m,
    input logic [REG_W-1:0] wr_m,
    input logic             rw_w,
    input logic [REG_W-1:0] wr_w
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (rw_m && (wr_m != '0) && (wr_m == src)) begin
      sel = FWD_M;
    end else if (rw_w && (wr_w != '0) && (wr_w == src)) begin
      sel = FWD_W;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_ctrl_pipe_stage_reg.sv
// Pipeline control register with synchronous reset and a bubble-insert clear.
module ctrl_stage_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         srst_i,
  input  logic         clr_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;

  always_ff @(posedge clk) begin
    if (srst_i || clr_i) begin
      q_q <= '0;
    end else begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/hazard_ctrl_pipe.sv
// Stage-qualified control for the 5-stage MIPS: carries the decode control word
// through E/M/W and resolves forwarding, load-use stalls and taken-branch flushes.
module hazard_ctrl_pipe
  import hazard_ctrl_pipe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                RegWriteD,
  input  logic                MemToRegD,
  input  logic                MemWriteD,
  input  logic                BranchD,
  input  logic                ALUSrcD,
  input  logic                RegDstD,
  input  logic [ALUCTL_W-1:0] ALUControlD,
  input  logic [REG_W-1:0]    RsD,
  input  logic [REG_W-1:0]    RtD,
  input  logic [REG_W-1:0]    RdD,
  input  logic                zero,
  output logic                ALUSrcE,
  output logic                RegDstE,
  output logic [ALUCTL_W-1:0] ALUControlE,
  output logic                MemWriteM,
  output logic                PCSrcM,
  output logic                RegWriteW,
  output logic                MemToRegW,
  output logic [REG_W-1:0]    WriteRegE,
  output logic [REG_W-1:0]    WriteRegM,
  output logic [REG_W-1:0]    WriteRegW,
  output logic [1:0]          ForwardAE,
  output logic [1:0]          ForwardBE,
  output logic                StallF,
  output logic                StallD,
  output logic                FlushD,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic [CNT_W-1:0]    flush_cnt
);

  de_word_t de_d, de_q;
  em_word_t em_d, em_q;
  mw_word_t mw_d, mw_q;

  logic lwstall;
  logic pcsrc;
  logic stall_evt;
  logic clr_e;
  logic clr_m;

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // ---------------------------------------------------------------- D -> E
  always_comb begin
    de_d            = '0;
    de_d.reg_write  = RegWriteD;
    de_d.mem_to_reg = MemToRegD;
    de_d.mem_write  = MemWriteD;
    de_d.branch     = BranchD;
    de_d.alu_src    = ALUSrcD;
    de_d.reg_dst    = RegDstD;
    de_d.alu_ctl    = ALUControlD;
    de_d.rs         = RsD;
    de_d.rt         = RtD;
    de_d.rd         = RdD;
  end

  ctrl_stage_reg #(.W($bits(de_word_t))) u_de_reg (
    .clk    (clk),
    .srst_i (reset),
    .clr_i  (clr_e),
    .d_i    (de_d),
    .q_o    (de_q)
  );

  assign WriteRegE   = de_q.reg_dst ? de_q.rd : de_q.rt;
  assign ALUSrcE     = de_q.alu_src;
  assign RegDstE     = de_q.reg_dst;
  assign ALUControlE = de_q.alu_ctl;

  // ---------------------------------------------------------------- E -> M
  always_comb begin
    em_d            = '0;
    em_d.reg_write  = de_q.reg_write;
    em_d.mem_to_reg = de_q.mem_to_reg;
    em_d.mem_write  = de_q.mem_write;
    em_d.branch     = de_q.branch;
    em_d.zero       = zero;
    em_d.write_reg  = WriteRegE;
  end

  ctrl_stage_reg #(.W($bits(em_word_t))) u_em_reg (
    .clk    (clk),
    .srst_i (reset),
    .clr_i  (clr_m),
    .d_i    (em_d),
    .q_o    (em_q)
  );

  assign MemWriteM = em_q.mem_write;
  assign WriteRegM = em_q.write_reg;

  // ---------------------------------------------------------------- M -> W
  always_comb begin
    mw_d            = '0;
    mw_d.reg_write  = em_q.reg_write;
    mw_d.mem_to_reg = em_q.mem_to_reg;
    mw_d.write_reg  = em_q.write_reg;
  end

  ctrl_stage_reg #(.W($bits(mw_word_t))) u_mw_reg (
    .clk    (clk),
    .srst_i (reset),
    .clr_i  (1'b0),
    .d_i    (mw_d),
    .q_o    (mw_q)
  );

  assign RegWriteW = mw_q.reg_write;
  assign MemToRegW = mw_q.mem_to_reg;
  assign WriteRegW = mw_q.write_reg;

  // ---------------------------------------------------------------- hazards
  assign pcsrc   = em_q.branch & em_q.zero;
  assign lwstall = de_q.mem_to_reg && (de_q.rt != '0) &&
                   ((de_q.rt == RsD) || (de_q.rt == RtD));

  // A taken branch kills the dependent instruction anyway, so it overrides the stall.
  assign stall_evt = lwstall & ~pcsrc;
  assign clr_e     = stall_evt | pcsrc;
  assign clr_m     = pcsrc;

  assign PCSrcM = pcsrc;
  assign StallF = stall_evt;
  assign StallD = stall_evt;
  assign FlushD = pcsrc;

  assign ForwardAE = fwd_sel(de_q.rs, em_q.reg_write, em_q.write_reg,
                             mw_q.reg_write, mw_q.write_reg);
  assign ForwardBE = fwd_sel(de_q.rt, em_q.reg_write, em_q.write_reg,
                             mw_q.reg_write, mw_q.write_reg);

  // ---------------------------------------------------------------- counters
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_evt && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (pcsrc && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_pipe.sv
// Directed bench for hazard_ctrl_pipe; narrow counters make saturation reachable.
module tb_hazard_ctrl_pipe;

  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             RegWriteD, MemToRegD, MemWriteD, BranchD, ALUSrcD, RegDstD;
  logic [2:0]       ALUControlD;
  logic [4:0]       RsD, RtD, RdD;
  logic             zero;
  logic             ALUSrcE, RegDstE;
  logic [2:0]       ALUControlE;
  logic             MemWriteM, PCSrcM, RegWriteW, MemToRegW;
  logic [4:0]       WriteRegE, WriteRegM, WriteRegW;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             StallF, StallD, FlushD;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int n_pass  = 0;
  int n_total = 0;
  int exp_stall;
  int exp_flush;

  hazard_ctrl_pipe #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .RegWriteD   (RegWriteD),
    .MemToRegD   (MemToRegD),
    .MemWriteD   (MemWriteD),
    .BranchD     (BranchD),
    .ALUSrcD     (ALUSrcD),
    .RegDstD     (RegDstD),
    .ALUControlD (ALUControlD),
    .RsD         (RsD),
    .RtD         (RtD),
    .RdD         (RdD),
    .zero        (zero),
    .ALUSrcE     (ALUSrcE),
    .RegDstE     (RegDstE),
    .ALUControlE (ALUControlE),
    .MemWriteM   (MemWriteM),
    .PCSrcM      (PCSrcM),
    .RegWriteW   (RegWriteW),
    .MemToRegW   (MemToRegW),
    .WriteRegE   (WriteRegE),
    .WriteRegM   (WriteRegM),
    .WriteRegW   (WriteRegW),
    .ForwardAE   (ForwardAE),
    .ForwardBE   (ForwardBE),
    .StallF      (StallF),
    .StallD      (StallD),
    .FlushD      (FlushD),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic set_d(input logic rw, input logic mtr, input logic mw, input logic br,
                       input logic as, input logic rdst, input logic [2:0] alu,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    RegWriteD = rw;  MemToRegD = mtr; MemWriteD = mw; BranchD = br;
    ALUSrcD   = as;  RegDstD   = rdst; ALUControlD = alu;
    RsD = rs; RtD = rt; RdD = rd;
  endtask

  task automatic bubble();
    set_d(0, 0, 0, 0, 0, 0, 3'b000, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic drain();
    bubble();
    tick(); tick(); tick();
  endtask

  initial begin
    // 1: reset with a random D word
    reset = 1'b1;
    zero  = 1'b0;
    {RegWriteD, MemToRegD, MemWriteD, BranchD, ALUSrcD, RegDstD} = 6'($urandom);
    ALUControlD = 3'($urandom);
    RsD = 5'($urandom); RtD = 5'($urandom); RdD = 5'($urandom);
    tick(); tick();
    $display("step reset");
    chk("rst_alusrce", ALUSrcE, 0);
    chk("rst_regdste", RegDstE, 0);
    chk("rst_aluctle", ALUControlE, 0);
    chk("rst_memwritem", MemWriteM, 0);
    chk("rst_regwritew", RegWriteW, 0);
    chk("rst_memtoregw", MemToRegW, 0);
    chk("rst_wrege", WriteRegE, 0);
    chk("rst_wregm", WriteRegM, 0);
    chk("rst_wregw", WriteRegW, 0);
    chk("rst_fwda", ForwardAE, 2'b00);
    chk("rst_fwdb", ForwardBE, 2'b00);
    chk("rst_stallf", StallF, 0);
    chk("rst_flushd", FlushD, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_flush_cnt", flush_cnt, 0);
    reset = 1'b0;
    drain();

    // 2: lw $2,0($1) ; add $3,$2,$4
    $display("step load-use");
    set_d(1, 1, 0, 0, 1, 0, 3'b010, 5'd1, 5'd2, 5'd0);
    tick();
    set_d(1, 0, 0, 0, 0, 1, 3'b010, 5'd2, 5'd4, 5'd3);
    chk("lu_stallf", StallF, 1);
    chk("lu_stalld", StallD, 1);
    chk("lu_flushd", FlushD, 0);
    chk("lu_wrege_lw", WriteRegE, 5'd2);
    tick();
    chk("lu_stallf_once", StallF, 0);
    chk("lu_bubble_alusrc", ALUSrcE, 0);
    chk("lu_bubble_wrege", WriteRegE, 0);
    chk("lu_stall_cnt", stall_cnt, 1);
    chk("lu_wregm", WriteRegM, 5'd2);
    tick();
    bubble();
    chk("lu_add_wrege", WriteRegE, 5'd3);
    chk("lu_fwda_w", ForwardAE, 2'b01);
    chk("lu_fwdb_rf", ForwardBE, 2'b00);
    chk("lu_memtoregw", MemToRegW, 1);
    chk("lu_wregw", WriteRegW, 5'd2);
    chk("lu_stall_cnt_hold", stall_cnt, 1);
    drain();

    // 3: add $2,$1,$1 ; sub $5,$2,$2
    $display("step ex-ex forward");
    set_d(1, 0, 0, 0, 0, 1, 3'b010, 5'd1, 5'd1, 5'd2);
    tick();
    set_d(1, 0, 0, 0, 0, 1, 3'b110, 5'd2, 5'd2, 5'd5);
    chk("fw_nostall_d", StallF, 0);
    tick();
    bubble();
    chk("fw_fwda_m", ForwardAE, 2'b10);
    chk("fw_fwdb_m", ForwardBE, 2'b10);
    chk("fw_nostall_e", StallD, 0);
    chk("fw_aluctle", ALUControlE, 3'b110);
    chk("fw_wrege", WriteRegE, 5'd5);
    chk("fw_stall_cnt", stall_cnt, 1);
    drain();

    // 4: M and W both write $7; then a write to $0 in M
    $display("step forward priority");
    set_d(1, 0, 0, 0, 0, 1, 3'b010, 5'd1, 5'd1, 5'd7);
    tick();
    set_d(1, 0, 0, 0, 0, 1, 3'b010, 5'd2, 5'd2, 5'd7);
    tick();
    set_d(1, 0, 0, 0, 0, 1, 3'b010, 5'd7, 5'd3, 5'd8);
    tick();
    set_d(1, 0, 0, 0, 0, 1, 3'b010, 5'd1, 5'd1, 5'd0);
    chk("pr_fwda_m_over_w", ForwardAE, 2'b10);
    chk("pr_fwdb_rf", ForwardBE, 2'b00);
    tick();
    set_d(0, 0, 0, 0, 0, 0, 3'b010, 5'd0, 5'd5, 5'd0);
    tick();
    bubble();
    chk("pr_wregm_zero", WriteRegM, 0);
    chk("pr_fwda_r0", ForwardAE, 2'b00);
    chk("pr_fwdb_r0", ForwardBE, 2'b00);
    drain();

    // 5: beq taken kills the two sw instructions behind it
    $display("step branch taken");
    set_d(0, 0, 0, 1, 0, 0, 3'b110, 5'd1, 5'd2, 5'd0);
    tick();
    set_d(0, 0, 1, 0, 1, 0, 3'b010, 5'd1, 5'd9, 5'd0);
    zero = 1'b1;
    tick();
    set_d(0, 0, 1, 0, 1, 0, 3'b010, 5'd1, 5'd10, 5'd0);
    zero = 1'b0;
    chk("br_pcsrcm", PCSrcM, 1);
    chk("br_flushd", FlushD, 1);
    chk("br_stallf", StallF, 0);
    chk("br_memwritem_beq", MemWriteM, 0);
    chk("br_flush_cnt_pre", flush_cnt, 0);
    tick();
    bubble();
    chk("br_pcsrc_clear", PCSrcM, 0);
    chk("br_killed_sw_m", MemWriteM, 0);
    chk("br_killed_e", ALUSrcE, 0);
    chk("br_flush_cnt", flush_cnt, 1);
    drain();
    set_d(0, 0, 0, 1, 0, 0, 3'b110, 5'd1, 5'd2, 5'd0);
    tick();
    bubble();
    tick();
    $display("step branch not taken");
    chk("bn_pcsrcm", PCSrcM, 0);
    chk("bn_flushd", FlushD, 0);
    chk("bn_flush_cnt", flush_cnt, 1);
    drain();

    // 6: lwstall and taken branch in the same cycle
    $display("step stall vs flush");
    set_d(0, 0, 0, 1, 0, 0, 3'b110, 5'd1, 5'd2, 5'd0);
    tick();
    set_d(1, 1, 0, 0, 1, 0, 3'b010, 5'd1, 5'd2, 5'd0);
    zero = 1'b1;
    tick();
    set_d(1, 0, 0, 0, 0, 1, 3'b010, 5'd2, 5'd4, 5'd3);
    zero = 1'b0;
    chk("sf_pcsrcm", PCSrcM, 1);
    chk("sf_stallf", StallF, 0);
    chk("sf_stalld", StallD, 0);
    chk("sf_flushd", FlushD, 1);
    tick();
    chk("sf_stall_cnt", stall_cnt, 1);
    chk("sf_flush_cnt", flush_cnt, 2);
    chk("sf_e_bubble", ALUSrcE, 0);
    drain();

    // saturation of stall_cnt (max 7 with CNT_W=3)
    exp_stall = 1;
    for (int i = 0; i < 8; i++) begin
      set_d(1, 1, 0, 0, 1, 0, 3'b010, 5'd1, 5'd2, 5'd0);
      tick();
      set_d(1, 0, 0, 0, 0, 1, 3'b010, 5'd2, 5'd4, 5'd3);
      chk("sat_stallf", StallF, 1);
      tick(); tick();
      bubble();
      tick();
      exp_stall = (exp_stall < 7) ? exp_stall + 1 : 7;
      $display("step stall sat iter=%0d stall_cnt=%0d", i, stall_cnt);
      chk("sat_stall_cnt", stall_cnt, 32'(exp_stall));
    end

    // saturation of flush_cnt
    exp_flush = 2;
    for (int i = 0; i < 6; i++) begin
      set_d(0, 0, 0, 1, 0, 0, 3'b110, 5'd1, 5'd2, 5'd0);
      tick();
      bubble();
      zero = 1'b1;
      tick();
      zero = 1'b0;
      chk("sat_pcsrcm", PCSrcM, 1);
      tick();
      exp_flush = (exp_flush < 7) ? exp_flush + 1 : 7;
      $display("step flush sat iter=%0d flush_cnt=%0d", i, flush_cnt);
      chk("sat_flush_cnt", flush_cnt, 32'(exp_flush));
    end
    drain();

    // reset in the middle of a pending load-use stall
    $display("step mid reset");
    set_d(1, 1, 0, 0, 1, 0, 3'b010, 5'd1, 5'd2, 5'd0);
    tick();
    set_d(1, 0, 0, 0, 0, 1, 3'b010, 5'd2, 5'd4, 5'd3);
    chk("mr_stall_before", StallF, 1);
    reset = 1'b1;
    tick();
    chk("mr_stallf", StallF, 0);
    chk("mr_alusrce", ALUSrcE, 0);
    chk("mr_wregm", WriteRegM, 0);
    chk("mr_stall_cnt", stall_cnt, 0);
    chk("mr_flush_cnt", flush_cnt, 0);
    reset = 1'b0;
    bubble();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
